tick_gen: RTL and testbench
===========================

TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 SHALL provide parameter DIV_W, default 27, width of divisor and counter.
REQ-002 SHALL provide parameter NUM_CH, default 2, number of independent divider channels (1..8).
REQ-003 SHALL provide parameter DEF_DIV, default 50000000, reset divisor of every channel (1 s tick at 100 MHz clk when DEF_DIV = 100000000; half-period when used via clk_out).
REQ-004 SHALL provide port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port en  input  1  global count enable.
REQ-007 SHALL provide port div_wr  input  1  one-cycle divisor write strobe.
REQ-008 SHALL provide port div_sel  input  3  channel index for div_wr; values >= NUM_CH ignored.
REQ-009 SHALL provide port div_data  input  DIV_W  new divisor value.
REQ-010 SHALL provide port tick  output  NUM_CH  per-channel one-cycle pulse, registered.
REQ-011 SHALL provide port clk_out  output  NUM_CH  per-channel toggle output (square wave, period 2*div cycles), registered.

Function
REQ-012 Each channel SHALL hold: counter[DIV_W], active divisor act[DIV_W], pending divisor pend[DIV_W], pending flag.
REQ-013 Effective divisor SHALL be act, with act = 0 treated as 1.
REQ-014 With en = 1, counter SHALL increment by 1 per cycle from 0 to eff-1, then return to 0 (wrap cycle).
REQ-015 On the wrap edge, tick[i] SHALL rise for exactly one cycle and clk_out[i] SHALL toggle on the same edge.
REQ-016 First tick after reset release with en held high SHALL occur on the eff-th rising edge after rst deasserts; thereafter exactly every eff cycles.
REQ-017 Effective divisor 1 SHALL give tick constantly high and clk_out toggling every cycle.
REQ-018 With en = 0, counter, clk_out and pending state SHALL hold; tick SHALL be 0.
REQ-019 div_wr with valid div_sel SHALL load div_data into pend and set pending flag; no other channel affected.
REQ-020 Pending divisor SHALL be copied into act at the next wrap edge (flag cleared); current period always completes with the old divisor.
REQ-021 div_wr in the same cycle as a wrap SHALL update pend only; the new value SHALL apply at the following wrap, not the current one.
REQ-022 Repeated div_wr before a wrap SHALL keep only the last value.
REQ-023 Counter arithmetic SHALL be DIV_W bits unsigned; no overflow possible since counter never exceeds eff-1.
REQ-024 Channels SHALL be fully independent apart from shared en, div bus and SYNC (below).

Reset
REQ-025 On rst = 1 at a rising edge: counter = 0, act = pend = DEF_DIV, pending flag = 0, tick = 0, clk_out = 0 for all channels.
REQ-026 rst SHALL take priority over en, div_wr and sync in the same cycle; reset mid-period SHALL discard partial count and pending writes.

Configuration
REQ-027 Macro TICK_GEN_SYNC_EN defined: SHALL add input port sync (1 bit); sync = 1 SHALL clear all counters and clk_out to 0, force tick to 0, and apply any pending divisor immediately, phase-aligning all channels; rst still has priority.
REQ-028 Macro TICK_GEN_SYNC_EN undefined: port sync SHALL not exist and behaviour SHALL be REQ-012..026 only.

Verification (NUM_CH = 2, DIV_W = 8, DEF_DIV = 4)
REQ-029 Reset, en = 1 for 20 cycles -> tick[0], tick[1] high on edges 4, 8, 12, 16, 20; clk_out toggles on same edges (0->1 at 4, 1->0 at 8).
REQ-030 en low for 3 cycles mid-period at counter = 2 -> next tick delayed by exactly 3 cycles; clk_out unchanged while low.
REQ-031 div_wr sel = 1 data = 6 at counter = 1 -> ch1 next tick still at 4-cycle spacing, then 6-cycle spacing; ch0 unaffected at 4.
REQ-032 div_wr coincident with wrap, data = 2 -> one more 4-cycle period, then 2-cycle spacing; data = 0 then -> tick every cycle.
REQ-033 div_wr sel = 5 -> no channel changes; rst asserted mid-period after pending write -> divisor returns to 4, first tick 4 cycles after release.
REQ-034 (TICK_GEN_SYNC_EN) ch0 = 4, ch1 = 6 running, pulse sync -> both counters 0, clk_out 0, ticks at +4/+6 cycles after sync edge.

Source files
------------

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen -- multi-channel programmable tick / square-wave generator
//
// Each of NUM_CH channels divides the system clock by its own divisor. On the
// last cycle of every period (the "wrap") the channel emits a one-cycle tick
// and toggles its clk_out, so clk_out has a period of 2*div cycles.
// Divisor changes are staged: a write lands in a pending register and only
// becomes active at the next wrap, so the period in progress always finishes
// with the old divisor.
//
// Optional feature (macro TICK_GEN_SYNC_EN): adds a sync input that restarts
// every channel at count 0 with clk_out low and applies any pending divisor
// at once, phase-aligning all channels.
//
// Parameters:
//   DIV_W    width of divisor and counter
//   NUM_CH   number of independent channels (1..8)
//   DEF_DIV  divisor loaded into every channel at reset
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset (highest priority)
//   en        in   global count enable
//   sync      in   (TICK_GEN_SYNC_EN only) restart / phase-align all channels
//   div_wr    in   one-cycle divisor write strobe
//   div_sel   in   target channel of div_wr; values >= NUM_CH are ignored
//   div_data  in   divisor value to write (0 behaves as 1)
//   tick      out  per-channel one-cycle pulse at each wrap, registered
//   clk_out   out  per-channel square wave toggling at each wrap, registered
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int unsigned DIV_W   = 27,
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned DEF_DIV = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
`ifdef TICK_GEN_SYNC_EN
    input  logic              sync,
`endif
    input  logic              div_wr,
    input  logic [2:0]        div_sel,
    input  logic [DIV_W-1:0]  div_data,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    logic [NUM_CH-1:0][DIV_W-1:0] cnt_q,  cnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0] act_q,  act_d;
    logic [NUM_CH-1:0][DIV_W-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0]            pflag_q, pflag_d;
    logic [NUM_CH-1:0]            tick_q,  tick_d;
    logic [NUM_CH-1:0]            clk_q,   clk_d;

    logic [NUM_CH-1:0][DIV_W-1:0] eff;
    logic [NUM_CH-1:0]            at_last;
    logic [NUM_CH-1:0]            wr_hit;
    logic                         sync_w;

`ifdef TICK_GEN_SYNC_EN
    assign sync_w = sync;
`else
    assign sync_w = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // A divisor of 0 is treated as 1 so the channel never stalls.
        assign eff[g]     = (act_q[g] == '0) ? ONE : act_q[g];
        // Counter sits on its last value of the period; with en this is a wrap.
        assign at_last[g] = (cnt_q[g] == eff[g] - ONE);
        // Only indices that exist are generated, so out-of-range div_sel
        // values can never match a channel.
        assign wr_hit[g]  = div_wr && (div_sel == 3'(g));
    end

    always_comb begin
        cnt_d   = cnt_q;
        act_d   = act_q;
        pend_d  = pend_q;
        pflag_d = pflag_q;
        tick_d  = '0;
        clk_d   = clk_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sync_w) begin
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
                if (pflag_q[i]) begin
                    act_d[i] = pend_q[i];
                end
                pflag_d[i] = 1'b0;
            end else if (en) begin
                if (at_last[i]) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    clk_d[i]  = ~clk_q[i];
                    if (pflag_q[i]) begin
                        act_d[i] = pend_q[i];
                    end
                    pflag_d[i] = 1'b0;
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE;
                end
            end
            // A write is evaluated after the wrap/sync update so that a write
            // landing on a wrap edge stays pending for the following period.
            if (wr_hit[i]) begin
                pend_d[i]  = div_data;
                pflag_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            act_q   <= {NUM_CH{DEF_DIV_V}};
            pend_q  <= {NUM_CH{DEF_DIV_V}};
            pflag_q <= '0;
            tick_q  <= '0;
            clk_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            pflag_q <= pflag_d;
            tick_q  <= tick_d;
            clk_q   <= clk_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_q;

endmodule

// File: tb/tb_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_tick_gen -- bench for tick_gen with NUM_CH = 2, DIV_W = 8, DEF_DIV = 4.
// A per-cycle reference model (elapsed cycles within the current period) is
// compared against tick/clk_out after every rising edge, and directed
// scenarios check recorded tick edge numbers against hand-computed lists.
// -----------------------------------------------------------------------------
module tb_tick_gen;

    localparam int DIV_W   = 8;
    localparam int NUM_CH  = 2;
    localparam int DEF_DIV = 4;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             en       = 1'b0;
    logic             sync     = 1'b0;
    logic             div_wr   = 1'b0;
    logic [2:0]       div_sel  = 3'd0;
    logic [DIV_W-1:0] div_data = '0;
    logic [1:0]       tick;
    logic [1:0]       clk_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int log0[$];
    int log1[$];

    // reference model state
    int       m_el[2];
    int       m_div[2];
    int       m_pend[2];
    bit       m_pf[2];
    logic [1:0] m_tick = 2'b00;
    logic [1:0] m_clk  = 2'b00;

    always #5 clk = ~clk;

    tick_gen #(
        .DIV_W   (DIV_W),
        .NUM_CH  (NUM_CH),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
`ifdef TICK_GEN_SYNC_EN
        .sync     (sync),
`endif
        .div_wr   (div_wr),
        .div_sel  (div_sel),
        .div_data (div_data),
        .tick     (tick),
        .clk_out  (clk_out)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_log(input string name, input int got[$], input int base, input int exp[$]);
        bit    ok;
        string gs;
        string es;
        ok = (got.size() == exp.size());
        gs = "";
        es = "";
        for (int i = 0; i < got.size(); i++) begin
            gs = $sformatf("%s %0d", gs, got[i] - base);
            if (i < exp.size() && (got[i] - base) != exp[i]) ok = 1'b0;
        end
        for (int i = 0; i < exp.size(); i++) es = $sformatf("%s %0d", es, exp[i]);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s tick edges got {%s } expected {%s }", name, gs, es);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model update and compare, once per rising edge.
    initial begin
        for (int c = 0; c < 2; c++) begin
            m_el[c] = 0; m_div[c] = DEF_DIV; m_pend[c] = DEF_DIV; m_pf[c] = 1'b0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int c = 0; c < 2; c++) begin
                if (rst) begin
                    m_el[c] = 0; m_div[c] = DEF_DIV; m_pend[c] = DEF_DIV; m_pf[c] = 1'b0;
                    m_tick[c] = 1'b0; m_clk[c] = 1'b0;
                end else begin
                    if (sync) begin
                        m_el[c] = 0; m_tick[c] = 1'b0; m_clk[c] = 1'b0;
                        if (m_pf[c]) m_div[c] = m_pend[c];
                        m_pf[c] = 1'b0;
                    end else if (en) begin
                        // elapsed enabled cycles in this period; the period
                        // ends once it reaches the effective divisor
                        m_el[c]++;
                        if (m_el[c] >= ((m_div[c] == 0) ? 1 : m_div[c])) begin
                            m_tick[c] = 1'b1;
                            m_clk[c]  = ~m_clk[c];
                            m_el[c]   = 0;
                            if (m_pf[c]) m_div[c] = m_pend[c];
                            m_pf[c] = 1'b0;
                        end else begin
                            m_tick[c] = 1'b0;
                        end
                    end else begin
                        m_tick[c] = 1'b0;
                    end
                    if (div_wr && int'(div_sel) == c) begin
                        m_pend[c] = int'(div_data);
                        m_pf[c]   = 1'b1;
                    end
                end
            end
            #1;
            chk("tick", {30'd0, tick}, {30'd0, m_tick});
            chk("clk_out", {30'd0, clk_out}, {30'd0, m_clk});
            if (tick[0]) log0.push_back(cyc);
            if (tick[1]) log1.push_back(cyc);
        end
    end

    // Directed scenarios.
    initial begin
        int t0;
        int t1;
        int t2;
        int t3;
        int t5;
        int t6;

        // reset with en high, then 20 enabled cycles
        rst = 1'b1; en = 1'b1;
        step(2);
        chk("reset_tick", {30'd0, tick}, 32'd0);
        chk("reset_clk_out", {30'd0, clk_out}, 32'd0);
        rst = 1'b0;
        t0 = cyc; log0.delete(); log1.delete();
        step(4);
        chk("first_tick_clk_out", {30'd0, clk_out}, 32'd3);
        step(16);
        check_log("run_ch0", log0, t0, '{4, 8, 12, 16, 20});
        check_log("run_ch1", log1, t0, '{4, 8, 12, 16, 20});
        chk("run_clk_out", {30'd0, clk_out}, 32'd3);

        // en low for 3 cycles with counter at 2
        t1 = cyc; log0.delete(); log1.delete();
        step(2);
        en = 1'b0;
        step(3);
        chk("hold_clk_out", {30'd0, clk_out}, 32'd3);
        chk("hold_tick", {30'd0, tick}, 32'd0);
        en = 1'b1;
        step(3);
        check_log("hold_ch0", log0, t1, '{7});
        check_log("hold_ch1", log1, t1, '{7});

        // ch1 divisor 6 written with counter at 1
        t2 = cyc; log0.delete(); log1.delete();
        div_wr = 1'b1; div_sel = 3'd1; div_data = 8'd6;
        step(1);
        div_wr = 1'b0;
        step(14);
        check_log("wr6_ch0", log0, t2, '{3, 7, 11, 15});
        check_log("wr6_ch1", log1, t2, '{3, 9, 15});

        // ch0: write 2 on a wrap edge, later write 0
        t3 = cyc; log0.delete(); log1.delete();
        step(3);
        div_wr = 1'b1; div_sel = 3'd0; div_data = 8'd2;
        step(1);
        div_wr = 1'b0;
        step(8);
        div_wr = 1'b1; div_sel = 3'd0; div_data = 8'd0;
        step(1);
        div_wr = 1'b0;
        step(5);
        check_log("wrap_wr_ch0", log0, t3, '{4, 8, 10, 12, 14, 15, 16, 17, 18});
        check_log("wrap_wr_ch1", log1, t3, '{6, 12, 18});
        chk("div0_tick0", {31'd0, tick[0]}, 32'd1);

        // out-of-range select, pending write, then reset mid-period
        div_wr = 1'b1; div_sel = 3'd5; div_data = 8'd9;
        step(1);
        div_wr = 1'b0;
        step(2);
        div_wr = 1'b1; div_sel = 3'd0; div_data = 8'd7;
        step(1);
        div_wr = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        t5 = cyc; log0.delete(); log1.delete();
        step(12);
        check_log("rst_ch0", log0, t5, '{4, 8, 12});
        check_log("rst_ch1", log1, t5, '{4, 8, 12});

`ifdef TICK_GEN_SYNC_EN
        // pending ch1 = 6 applied by sync landing on a wrap edge
        step(2);
        div_wr = 1'b1; div_sel = 3'd1; div_data = 8'd6;
        step(1);
        div_wr = 1'b0; sync = 1'b1;
        step(1);
        sync = 1'b0;
        t6 = cyc; log0.delete(); log1.delete();
        chk("sync_clk_out", {30'd0, clk_out}, 32'd0);
        chk("sync_tick", {30'd0, tick}, 32'd0);
        step(12);
        check_log("sync_ch0", log0, t6, '{4, 8, 12});
        check_log("sync_ch1", log1, t6, '{6, 12});
`else
        t6 = 0;
`endif

        step(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
